dec_secded_16: RTL

Pipelined SECDED decoder for the 16-bit extended-Hamming codewords produced by the encode path (11 data bits, 4 Hamming parity bits, 1 overall parity bit). It accepts one codeword per cycle over a valid/ready handshake. It corrects any single-bit error, flags double-bit errors, and keeps saturating error counters. It sits on the receive side, between the channel/storage read port and the data consumer.

---
 rtl/dec_secded_16.sv | 110 +++++++++++
 1 files changed

// File: rtl/dec_secded_16.sv
// Two-stage SECDED decoder for 16-bit extended-Hamming codewords.
// Stage 1 registers syndrome and overall parity; stage 2 corrects, classifies and counts.
module dec_secded_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_cw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_data,
    output logic        out_err_single,
    output logic        out_err_double,
    output logic [3:0]  out_err_pos,
    input  logic        clr_cnt,
    output logic [7:0]  cnt_single,
    output logic [7:0]  cnt_double
);

    logic        s1_valid;
    logic [15:0] s1_cw;
    logic [3:0]  s1_syn;
    logic        s1_q;

    logic [3:0]  syn;
    logic        q;
    logic        adv2;
    logic        handoff;

    logic [15:0] fixed_cw;
    logic [10:0] nxt_data;
    logic        nxt_single;
    logic        nxt_double;
    logic [3:0]  nxt_pos;

    // Each syndrome bit covers the positions whose index has that bit set.
    assign syn[0] = ^(in_cw & 16'hAAAA);
    assign syn[1] = ^(in_cw & 16'hCCCC);
    assign syn[2] = ^(in_cw & 16'hF0F0);
    assign syn[3] = ^(in_cw & 16'hFF00);
    assign q      = ^in_cw;

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign handoff  = out_valid && out_ready;

    always_comb begin
        fixed_cw   = s1_cw;
        nxt_single = 1'b0;
        nxt_double = 1'b0;
        nxt_pos    = 4'd0;
        if (s1_syn == 4'd0) begin
            nxt_single = s1_q;
        end else if (s1_q) begin
            fixed_cw[s1_syn] = ~s1_cw[s1_syn];
            nxt_single       = 1'b1;
            nxt_pos          = s1_syn;
        end else begin
            nxt_double = 1'b1;
        end
        nxt_data = {fixed_cw[15:9], fixed_cw[7:5], fixed_cw[3]};
    end

    // NOTE: all state updates use <= so every register samples pre-edge values,
    // which is what lets stage 1 refill in the same cycle stage 2 consumes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_cw          <= '0;
            s1_syn         <= '0;
            s1_q           <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_err_single <= 1'b0;
            out_err_double <= 1'b0;
            out_err_pos    <= '0;
            cnt_single     <= '0;
            cnt_double     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cw  <= in_cw;
                    s1_syn <= syn;
                    s1_q   <= q;
                end
            end

            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data       <= nxt_data;
                    out_err_single <= nxt_single;
                    out_err_double <= nxt_double;
                    out_err_pos    <= nxt_pos;
                end
            end

            // Clear takes priority over a same-cycle flagged handoff.
            if (clr_cnt) begin
                cnt_single <= '0;
                cnt_double <= '0;
            end else if (handoff) begin
                if (out_err_single && cnt_single != 8'hFF) cnt_single <= cnt_single + 8'd1;
                if (out_err_double && cnt_double != 8'hFF) cnt_double <= cnt_double + 8'd1;
            end
        end
    end

endmodule
